alu_arbiter: RTL and testbench

//  Shares the single execute-stage ALU between two requesters (req0 = integer pipe, req1 = branch/address unit).
//  2-way round-robin grant per cycle, valid/ready issue handshake, tracks each op through the ALU's fixed
//  2-cycle latency and routes the result back to its owner. Sits between the decode/issue logic and the ALU.

---
 rtl/riscv_alu_pkg.sv | 43 ++++
 rtl/alu_arb_rr.sv | 31 +++
 rtl/alu_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_alu_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_alu_pkg
//  Description : Shared definitions for the execute-stage ALU and its
//                arbiter: op encodings, ALU latency, the in-flight tag type
//                and a saturating counter helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_alu_pkg;

  // Issue-to-result latency of the current ALU, in cycles.
  localparam int ALU_LAT = 2;

  typedef enum logic [3:0] {
    ALU_NOP  = 4'b0000,
    ALU_ADD  = 4'b0001,
    ALU_SUB  = 4'b0010,
    ALU_SLT  = 4'b0011,
    ALU_AND  = 4'b0100,
    ALU_OR   = 4'b0101,
    ALU_XOR  = 4'b0110,
    ALU_SLL  = 4'b0111,
    ALU_SRL  = 4'b1000,
    ALU_SRA  = 4'b1001,
    ALU_SLTU = 4'b1011
  } alu_op_e;

  // One entry of the in-flight tracking pipe: is an op present, and who owns it.
  typedef struct packed {
    logic valid;
    logic owner;  // 0 = req0 (integer pipe), 1 = req1 (branch/address unit)
  } alu_tag_t;

  // 16-bit increment that sticks at all-ones.
  function automatic logic [15:0] sat_inc16(input logic [15:0] val, input logic en);
    if (en && (val != 16'hFFFF)) begin
      return val + 16'd1;
    end
    return val;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_arb_rr.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arb_rr
//  Description : Two-way round-robin picker. A lone requester always wins;
//                on contention the side that did not win last time wins.
//  Ports       : valid0/valid1 (in)  requests
//                last_grant    (in)  owner of the most recent accepted issue
//                grant         (out) winning side (0 = req0, 1 = req1)
//                any           (out) at least one request present
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_arb_rr (
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic grant,
  output logic any
);

  always_comb begin
    grant = 1'b0;
    any   = valid0 | valid1;
    if (valid0 && valid1) begin
      grant = ~last_grant;
    end else if (valid1) begin
      grant = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arbiter
//  Description : Shares the single execute-stage ALU between the integer pipe
//                (req0) and the branch/address unit (req1). Round-robin issue
//                with a valid/ready handshake, tracks each op through the
//                fixed ALU latency and routes the result back to its owner.
//  Ports       : clk, rst_n (sync, active-low), halt, flush
//                req0_*/req1_* : valid/ready/op/a/b issue interface
//                rsp0_*/rsp1_* : valid/data/zero/err result interface
//                alu_*         : drive to / results from the ALU
//  Config      : ALU_ARB_PERF_CNT_EN adds grant_cnt0, grant_cnt1 and
//                conflict_cnt saturating 16-bit performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
  parameter int              DATA_W  = 32,
  parameter int              OP_W    = 4,
  parameter int              ALU_LAT = 2,
  parameter logic [OP_W-1:0] OP_NOP  = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              halt,
  input  logic              flush,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_data,
  output logic              rsp0_zero,
  output logic              rsp0_err,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_data,
  output logic              rsp1_zero,
  output logic              rsp1_err,
  output logic              alu_en,
  output logic [OP_W-1:0]   alu_op_val,
  output logic [DATA_W-1:0] alu_operand_a,
  output logic [DATA_W-1:0] alu_operand_b,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zero_flag,
  input  logic              alu_done
`ifdef ALU_ARB_PERF_CNT_EN
  ,
  output logic [15:0]       grant_cnt0,
  output logic [15:0]       grant_cnt1,
  output logic [15:0]       conflict_cnt
`endif
);

  import riscv_alu_pkg::*;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  alu_tag_t          tag_q [ALU_LAT];
  alu_tag_t          tag_d [ALU_LAT];
  logic              last_grant_q, last_grant_d;
  logic [DATA_W-1:0] rsp0_data_q, rsp0_data_d;
  logic [DATA_W-1:0] rsp1_data_q, rsp1_data_d;
  logic              rsp0_zero_q, rsp0_zero_d;
  logic              rsp1_zero_q, rsp1_zero_d;

  logic     grant;
  logic     any_valid;
  logic     accept;
  alu_tag_t out_tag;
  logic     rsp0_fire;
  logic     rsp1_fire;

  // --------------------------------------------------------------------------
  // Arbitration and issue
  // --------------------------------------------------------------------------
  alu_arb_rr u_arb (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .last_grant (last_grant_q),
    .grant      (grant),
    .any        (any_valid)
  );

  // Nothing is accepted while in reset: the op would be lost when the tag
  // pipe clears, so the requester keeps it instead.
  assign accept     = any_valid & ~halt & ~flush & rst_n;
  assign req0_ready = accept & ~grant;
  assign req1_ready = accept & grant;

  assign alu_en = 1'b1;

  always_comb begin
    alu_op_val    = OP_NOP;
    alu_operand_a = '0;
    alu_operand_b = '0;
    if (accept) begin
      alu_op_val    = grant ? req1_op : req0_op;
      alu_operand_a = grant ? req1_a  : req0_a;
      alu_operand_b = grant ? req1_b  : req0_b;
    end
  end

  // --------------------------------------------------------------------------
  // Tag pipe: mirrors the ALU pipeline so the result leaving the ALU can be
  // matched to its owner. It freezes with the ALU on halt; flush only clears
  // valids, so the ALU's result for a killed op simply goes nowhere.
  // --------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < ALU_LAT; i++) begin
      tag_d[i] = tag_q[i];
    end
    last_grant_d = accept ? grant : last_grant_q;
    if (!halt) begin
      tag_d[0].valid = accept;
      tag_d[0].owner = grant;
      for (int i = 1; i < ALU_LAT; i++) begin
        tag_d[i] = tag_q[i-1];
      end
    end
    if (flush) begin
      for (int i = 0; i < ALU_LAT; i++) begin
        tag_d[i].valid = 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Response routing. Data/zero pass straight through from the ALU on the
  // response cycle and are otherwise held at the owner's last result.
  // --------------------------------------------------------------------------
  assign out_tag   = tag_q[ALU_LAT-1];
  assign rsp0_fire = out_tag.valid & ~out_tag.owner & ~halt;
  assign rsp1_fire = out_tag.valid &  out_tag.owner & ~halt;

  always_comb begin
    rsp0_data_d = rsp0_fire ? alu_out       : rsp0_data_q;
    rsp0_zero_d = rsp0_fire ? alu_zero_flag : rsp0_zero_q;
    rsp1_data_d = rsp1_fire ? alu_out       : rsp1_data_q;
    rsp1_zero_d = rsp1_fire ? alu_zero_flag : rsp1_zero_q;
  end

  assign rsp0_valid = rsp0_fire;
  assign rsp0_data  = rsp0_data_d;
  assign rsp0_zero  = rsp0_zero_d;
  assign rsp0_err   = rsp0_fire & ~alu_done;
  assign rsp1_valid = rsp1_fire;
  assign rsp1_data  = rsp1_data_d;
  assign rsp1_zero  = rsp1_zero_d;
  assign rsp1_err   = rsp1_fire & ~alu_done;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ALU_LAT; i++) begin
        tag_q[i] <= '0;
      end
      last_grant_q <= 1'b1;  // req0 wins the first tie
      rsp0_data_q  <= '0;
      rsp0_zero_q  <= 1'b0;
      rsp1_data_q  <= '0;
      rsp1_zero_q  <= 1'b0;
    end else begin
      for (int i = 0; i < ALU_LAT; i++) begin
        tag_q[i] <= tag_d[i];
      end
      last_grant_q <= last_grant_d;
      rsp0_data_q  <= rsp0_data_d;
      rsp0_zero_q  <= rsp0_zero_d;
      rsp1_data_q  <= rsp1_data_d;
      rsp1_zero_q  <= rsp1_zero_d;
    end
  end

`ifdef ALU_ARB_PERF_CNT_EN
  // --------------------------------------------------------------------------
  // Performance counters
  // --------------------------------------------------------------------------
  logic [15:0] grant_cnt0_q, grant_cnt0_d;
  logic [15:0] grant_cnt1_q, grant_cnt1_d;
  logic [15:0] conflict_cnt_q, conflict_cnt_d;

  always_comb begin
    grant_cnt0_d   = sat_inc16(grant_cnt0_q, req0_ready);
    grant_cnt1_d   = sat_inc16(grant_cnt1_q, req1_ready);
    conflict_cnt_d = sat_inc16(conflict_cnt_q, req0_valid & req1_valid & ~halt);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant_cnt0_q   <= '0;
      grant_cnt1_q   <= '0;
      conflict_cnt_q <= '0;
    end else begin
      grant_cnt0_q   <= grant_cnt0_d;
      grant_cnt1_q   <= grant_cnt1_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign grant_cnt0   = grant_cnt0_q;
  assign grant_cnt1   = grant_cnt1_q;
  assign conflict_cnt = conflict_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_arbiter
//  Description : Directed bench for alu_arbiter with a behavioural two-stage
//                ALU that freezes on halt like the real one.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

  localparam int DATA_W = 32;
  localparam int OP_W   = 4;

  logic              clk = 1'b0;
  logic              rst_n, halt, flush;
  logic              req0_valid, req0_ready, req1_valid, req1_ready;
  logic [OP_W-1:0]   req0_op, req1_op;
  logic [DATA_W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic              rsp0_valid, rsp0_zero, rsp0_err;
  logic              rsp1_valid, rsp1_zero, rsp1_err;
  logic [DATA_W-1:0] rsp0_data, rsp1_data;
  logic              alu_en;
  logic [OP_W-1:0]   alu_op_val;
  logic [DATA_W-1:0] alu_operand_a, alu_operand_b, alu_out;
  logic              alu_zero_flag, alu_done;
`ifdef ALU_ARB_PERF_CNT_EN
  logic [15:0]       grant_cnt0, grant_cnt1, conflict_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_W(DATA_W), .OP_W(OP_W), .ALU_LAT(2), .OP_NOP(4'b0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .halt          (halt),
    .flush         (flush),
    .req0_valid    (req0_valid),
    .req0_ready    (req0_ready),
    .req0_op       (req0_op),
    .req0_a        (req0_a),
    .req0_b        (req0_b),
    .req1_valid    (req1_valid),
    .req1_ready    (req1_ready),
    .req1_op       (req1_op),
    .req1_a        (req1_a),
    .req1_b        (req1_b),
    .rsp0_valid    (rsp0_valid),
    .rsp0_data     (rsp0_data),
    .rsp0_zero     (rsp0_zero),
    .rsp0_err      (rsp0_err),
    .rsp1_valid    (rsp1_valid),
    .rsp1_data     (rsp1_data),
    .rsp1_zero     (rsp1_zero),
    .rsp1_err      (rsp1_err),
    .alu_en        (alu_en),
    .alu_op_val    (alu_op_val),
    .alu_operand_a (alu_operand_a),
    .alu_operand_b (alu_operand_b),
    .alu_out       (alu_out),
    .alu_zero_flag (alu_zero_flag),
    .alu_done      (alu_done)
`ifdef ALU_ARB_PERF_CNT_EN
    ,
    .grant_cnt0    (grant_cnt0),
    .grant_cnt1    (grant_cnt1),
    .conflict_cnt  (conflict_cnt)
`endif
  );

  // --------------------------------------------------------------------------
  // Behavioural ALU: two registered stages, held on halt. Unknown ops and NOP
  // give result 0 with done low.
  // --------------------------------------------------------------------------
  function automatic logic [DATA_W:0] alu_calc(input logic [3:0] op,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
    case (op)
      4'b0001: return {1'b1, a + b};
      4'b0010: return {1'b1, a - b};
      4'b0011: return {1'b1, 31'd0, ($signed(a) < $signed(b))};
      4'b1011: return {1'b1, 31'd0, (a < b)};
      4'b0100: return {1'b1, a & b};
      4'b0101: return {1'b1, a | b};
      4'b0110: return {1'b1, a ^ b};
      4'b0111: return {1'b1, a << b[4:0]};
      4'b1000: return {1'b1, a >> b[4:0]};
      4'b1001: return {1'b1, $signed(a) >>> b[4:0]};
      default: return {1'b0, 32'd0};
    endcase
  endfunction

  logic [DATA_W-1:0] m_res1, m_out;
  logic              m_done1, m_done;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_res1  <= '0;
      m_done1 <= 1'b0;
      m_out   <= '0;
      m_done  <= 1'b0;
    end else if (!halt) begin
      {m_done1, m_res1} <= alu_calc(alu_op_val, alu_operand_a, alu_operand_b);
      m_out  <= m_res1;
      m_done <= m_done1;
    end
  end

  assign alu_out       = m_out;
  assign alu_done      = m_done;
  assign alu_zero_flag = (m_out == '0);

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    halt       = 1'b0;
    flush      = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_op    = '0;
    req1_op    = '0;
    req0_a     = '0;
    req0_b     = '0;
    req1_a     = '0;
    req1_b     = '0;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    // ---- 1: reset state, single ADD on req0 ----
    do_reset();
    mid();
    check_eq("rst_ready0",  req0_ready, 0);
    check_eq("rst_rsp0v",   rsp0_valid, 0);
    check_eq("rst_rsp1v",   rsp1_valid, 0);
    check_eq("rst_rsp0d",   rsp0_data, 0);
    check_eq("rst_rsp0e",   rsp0_err, 0);
    check_eq("rst_aluop",   alu_op_val, 0);
    check_eq("rst_opa",     alu_operand_a, 0);
    check_eq("alu_en",      alu_en, 1);
    next_cycle();
    req0_valid = 1'b1; req0_op = 4'b0001; req0_a = 32'd5; req0_b = 32'd7;
    mid();
    check_eq("t1_ready0",   req0_ready, 1);
    check_eq("t1_aluop",    alu_op_val, 4'b0001);
    check_eq("t1_opa",      alu_operand_a, 5);
    check_eq("t1_opb",      alu_operand_b, 7);
    next_cycle();
    req0_valid = 1'b0;
    mid();
    check_eq("t1_rsp0v_t1", rsp0_valid, 0);
    check_eq("t1_idle_op",  alu_op_val, 0);
    next_cycle();
    mid();
    check_eq("t1_rsp0v_t2", rsp0_valid, 1);
    check_eq("t1_rsp0d",    rsp0_data, 12);
    check_eq("t1_rsp0z",    rsp0_zero, 0);
    check_eq("t1_rsp0e",    rsp0_err, 0);
    check_eq("t1_rsp1v",    rsp1_valid, 0);
    next_cycle();
    mid();
    check_eq("t1_rsp0v_t3", rsp0_valid, 0);
    check_eq("t1_hold_d",   rsp0_data, 12);

    // ---- 2: contention, alternating grants starting with req0 ----
    do_reset();
    req0_op = 4'b0010; req0_a = 32'd9; req0_b = 32'd9;
    req1_op = 4'b0101; req1_a = 32'd1; req1_b = 32'd2;
    for (int c = 0; c < 6; c++) begin
      req0_valid = (c < 4);
      req1_valid = (c < 4);
      mid();
      if (c < 4) begin
        check_eq($sformatf("t2_ready0_c%0d", c), req0_ready, (c % 2 == 0));
        check_eq($sformatf("t2_ready1_c%0d", c), req1_ready, (c % 2 == 1));
      end
      if (c >= 2) begin
        check_eq($sformatf("t2_rsp0v_c%0d", c), rsp0_valid, (c % 2 == 0));
        check_eq($sformatf("t2_rsp1v_c%0d", c), rsp1_valid, (c % 2 == 1));
        if (c % 2 == 0) begin
          check_eq($sformatf("t2_rsp0d_c%0d", c), rsp0_data, 0);
          check_eq($sformatf("t2_rsp0z_c%0d", c), rsp0_zero, 1);
        end else begin
          check_eq($sformatf("t2_rsp1d_c%0d", c), rsp1_data, 3);
          check_eq($sformatf("t2_rsp1z_c%0d", c), rsp1_zero, 0);
        end
      end
      next_cycle();
    end

    // ---- 3: req1 SLT, then halt for 3 cycles ----
    do_reset();
    req1_valid = 1'b1; req1_op = 4'b0011; req1_a = 32'hFFFF_FFFF; req1_b = 32'd1;
    mid();
    check_eq("t3_ready1",   req1_ready, 1);
    next_cycle();
    req1_valid = 1'b0;
    halt       = 1'b1;
    req0_valid = 1'b1; req0_op = 4'b0001; req0_a = 32'd1; req0_b = 32'd1;
    for (int h = 0; h < 3; h++) begin
      mid();
      check_eq($sformatf("t3_halt_rsp1v_%0d", h), rsp1_valid, 0);
      check_eq($sformatf("t3_halt_ready0_%0d", h), req0_ready, 0);
      next_cycle();
    end
    halt       = 1'b0;
    req0_valid = 1'b0;
    mid();
    check_eq("t3_rsp1v_t4", rsp1_valid, 0);
    next_cycle();
    mid();
    check_eq("t3_rsp1v_t5", rsp1_valid, 1);
    check_eq("t3_rsp1d",    rsp1_data, 1);
    check_eq("t3_rsp1e",    rsp1_err, 0);
    check_eq("t3_rsp0v",    rsp0_valid, 0);

    // ---- 4: flush kills req0 XOR, req1 AND afterwards returns normally ----
    do_reset();
    req0_valid = 1'b1; req0_op = 4'b0110; req0_a = 32'd6; req0_b = 32'd3;
    mid();
    check_eq("t4_ready0",   req0_ready, 1);
    next_cycle();
    req0_valid = 1'b0;
    flush      = 1'b1;
    req1_valid = 1'b1; req1_op = 4'b0100; req1_a = 32'd12; req1_b = 32'd10;
    mid();
    check_eq("t4_flush_rdy1", req1_ready, 0);
    check_eq("t4_flush_op",   alu_op_val, 0);
    next_cycle();
    flush = 1'b0;
    mid();
    check_eq("t4_ready1",   req1_ready, 1);
    check_eq("t4_rsp0v_t2", rsp0_valid, 0);
    next_cycle();
    req1_valid = 1'b0;
    mid();
    check_eq("t4_rsp0v_t3", rsp0_valid, 0);
    check_eq("t4_rsp1v_t3", rsp1_valid, 0);
    next_cycle();
    mid();
    check_eq("t4_rsp1v_t4", rsp1_valid, 1);
    check_eq("t4_rsp1d",    rsp1_data, 8);
    check_eq("t4_rsp0v_t4", rsp0_valid, 0);

    // ---- 5: unrecognised op reports an error ----
    do_reset();
    req0_valid = 1'b1; req0_op = 4'b1111; req0_a = 32'd3; req0_b = 32'd4;
    mid();
    check_eq("t5_ready0",   req0_ready, 1);
    next_cycle();
    req0_valid = 1'b0;
    next_cycle();
    mid();
    check_eq("t5_rsp0v",    rsp0_valid, 1);
    check_eq("t5_rsp0e",    rsp0_err, 1);
    check_eq("t5_rsp0d",    rsp0_data, 0);

`ifdef ALU_ARB_PERF_CNT_EN
    // ---- 6: performance counters over 10 contended cycles ----
    do_reset();
    req0_valid = 1'b1; req0_op = 4'b0001;
    req1_valid = 1'b1; req1_op = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      next_cycle();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    mid();
    check_eq("t6_gcnt0",    grant_cnt0, 5);
    check_eq("t6_gcnt1",    grant_cnt1, 5);
    check_eq("t6_ccnt",     conflict_cnt, 10);
`endif

    next_cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
